// File: rtl/bdd_eval_walker.sv
// bdd_eval_walker
//   Walks a BDD stored in an external node-table sram. Starting from a root
//   address, each internal node is fetched, its variable is looked up in the
//   latched assignment vector, and the walk follows the high or low child
//   until a terminal node is reached. The walk reports the terminal value,
//   the number of internal nodes traversed, and an error flag. The error flag
//   is raised when a node references a variable outside the assignment vector,
//   or when MAX_STEPS internal nodes have been visited. The step limit is the
//   only cycle detection.
//
// Ports
//   i_clk, i_rst   clock and synchronous active-high reset
//   i_start        start request, sampled only while idle
//   i_root         root node address, latched on an accepted start
//   i_assign       variable values, latched on an accepted start
//   o_mem_addr     registered sram read address
//   o_mem_write    sram write enable, tied low
//   i_mem_data     sram read data, valid one cycle after o_mem_addr
//   o_busy         walk in progress (address/read phases)
//   o_done         one-cycle end-of-walk pulse
//   o_result       terminal value, held until the next start
//   o_error        walk aborted, held until the next start
//   o_steps        internal nodes traversed, held until the next start

module bdd_eval_walker #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int VAR_WIDTH  = 4,
  parameter int NUM_VARS   = 16,
  parameter int MAX_STEPS  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_root,
  input  logic [NUM_VARS-1:0]   i_assign,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_result,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_steps
);

  localparam int NUM_IDX = 2 ** VAR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_STEPS_W = (ADDR_WIDTH + 1)'(MAX_STEPS);
  localparam logic [ADDR_WIDTH:0] STEP_ONE    = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_READ,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [NUM_VARS-1:0]     assign_vec_q, assign_vec_d;
  logic [ADDR_WIDTH:0]     steps_q, steps_d;
  logic                    result_q, result_d;
  logic                    error_q, error_d;

  // Node word fields
  logic                    node_term;
  logic                    node_value;
  logic [VAR_WIDTH-1:0]    node_var;
  logic [ADDR_WIDTH-1:0]   node_hi;
  logic [ADDR_WIDTH-1:0]   node_lo;
  logic                    var_oob;
  logic                    var_value;

  assign node_term  = i_mem_data[DATA_WIDTH-1];
  assign node_value = i_mem_data[0];
  assign node_var   = i_mem_data[2*ADDR_WIDTH+VAR_WIDTH-1 : 2*ADDR_WIDTH];
  assign node_hi    = i_mem_data[2*ADDR_WIDTH-1 : ADDR_WIDTH];
  assign node_lo    = i_mem_data[ADDR_WIDTH-1 : 0];

  // Bits of the node word that carry no meaning are deliberately ignored.
  logic unused_mem_bits;
  assign unused_mem_bits = ^i_mem_data;

  // The assignment vector is padded out to the full var-index range so that
  // any index the node word can encode selects a defined bit. Indices at or
  // above NUM_VARS are rejected separately through var_oob.
  logic [NUM_IDX-1:0] assign_ext;

  generate
    for (genvar gi = 0; gi < NUM_IDX; gi++) begin : g_assign_ext
      if (gi < NUM_VARS) begin : g_live
        assign assign_ext[gi] = assign_vec_q[gi];
      end else begin : g_pad
        assign assign_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign var_oob   = (32'(node_var) >= NUM_VARS);
  assign var_value = assign_ext[node_var];

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      mem_addr_q   <= '0;
      assign_vec_q <= '0;
      steps_q      <= '0;
      result_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      assign_vec_q <= assign_vec_d;
      steps_q      <= steps_d;
      result_q     <= result_d;
      error_q      <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    assign_vec_d = assign_vec_q;
    steps_d      = steps_q;
    result_d     = result_q;
    error_d      = error_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          assign_vec_d = i_assign;
          mem_addr_d   = i_root;
          steps_d      = '0;
          result_d     = 1'b0;
          error_d      = 1'b0;
          state_d      = ST_ADDR;
        end
      end

      // The sram captures o_mem_addr at the end of this cycle.
      ST_ADDR: begin
        state_d = ST_READ;
      end

      ST_READ: begin
        state_d = ST_DONE;
        if (node_term) begin
          result_d = node_value;
        end else if (var_oob) begin
          error_d = 1'b1;
        end else if (steps_q == MAX_STEPS_W) begin
          // Step budget already spent: treat as a cyclic table.
          error_d = 1'b1;
        end else begin
          mem_addr_d = var_value ? node_hi : node_lo;
          steps_d    = steps_q + STEP_ONE;
          state_d    = ST_ADDR;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_mem_addr  = mem_addr_q;
  assign o_mem_write = 1'b0;
  assign o_busy      = (state_q == ST_ADDR) || (state_q == ST_READ);
  assign o_done      = (state_q == ST_DONE);
  assign o_result    = result_q;
  assign o_error     = error_q;
  assign o_steps     = steps_q;

endmodule

// File: tb/tb_bdd_eval_walker.sv
module tb_bdd_eval_walker;

  logic        clk;
  logic        rst;
  logic [1:0]  start;
  logic [3:0]  root [2];
  logic [15:0] asg0;
  logic [7:0]  asg1;
  logic [3:0]  mem_addr [2];
  logic [1:0]  mem_write;
  logic [31:0] rdata [2];
  logic [1:0]  busy, done, result, error;
  logic [4:0]  steps [2];

  logic [31:0] mem [16];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Node-table sram models, one read port per walker, 1-cycle latency.
  always @(posedge clk) begin
    rdata[0] <= mem[mem_addr[0]];
    rdata[1] <= mem[mem_addr[1]];
  end

  // Walker with the full 16-variable vector.
  bdd_eval_walker #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .VAR_WIDTH(4), .NUM_VARS(16), .MAX_STEPS(16)
  ) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_root(root[0]), .i_assign(asg0),
    .o_mem_addr(mem_addr[0]), .o_mem_write(mem_write[0]), .i_mem_data(rdata[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_result(result[0]), .o_error(error[0]),
    .o_steps(steps[0])
  );

  // Walker with only 8 variables, for the out-of-range variable case.
  bdd_eval_walker #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .VAR_WIDTH(4), .NUM_VARS(8), .MAX_STEPS(16)
  ) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_root(root[1]), .i_assign(asg1),
    .o_mem_addr(mem_addr[1]), .o_mem_write(mem_write[1]), .i_mem_data(rdata[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_result(result[1]), .o_error(error[1]),
    .o_steps(steps[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch a walk on walker d from an idle cycle and check its outcome.
  // exp_lat counts cycles from the accepting edge to the o_done cycle.
  // With poke set, a second start (root=1) is pulsed mid-walk and must be ignored.
  task automatic run_walk(input int d, input logic [3:0] r, input logic [15:0] a,
                          input int exp_lat, input logic exp_res, input logic exp_err,
                          input logic [4:0] exp_steps, input bit poke, input string tag);
    int cnt;
    root[d] = r;
    if (d == 0) asg0 = a;
    else asg1 = a[7:0];
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    cnt = 1;
    check({tag, "/busy"}, 32'(busy[d]), 32'd1);
    while (!done[d] && cnt < 100) begin
      if (poke && cnt == 2) begin
        start[d] = 1'b1;
        root[d]  = 4'd1;
      end
      if (poke && cnt == 3) start[d] = 1'b0;
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "/latency"}, 32'(cnt), 32'(exp_lat));
    check({tag, "/result"}, 32'(result[d]), 32'(exp_res));
    check({tag, "/error"}, 32'(error[d]), 32'(exp_err));
    check({tag, "/steps"}, 32'(steps[d]), 32'(exp_steps));
    check({tag, "/busy_at_done"}, 32'(busy[d]), 32'd0);
    @(posedge clk); #1;
    check({tag, "/done_pulse"}, 32'(done[d]), 32'd0);
    check({tag, "/result_held"}, 32'(result[d]), 32'(exp_res));
    $display("walk %s: dut%0d root=%0d lat=%0d result=%0b error=%0b steps=%0d",
             tag, d, r, cnt, result[d], error[d], steps[d]);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 16; i++) mem[i] = 32'h8000_0000;
    mem[0] = 32'h0000_0012;  // var0, hi=1, lo=2
    mem[1] = 32'h8000_0001;  // terminal 1
    mem[2] = 32'h8000_0000;  // terminal 0
    mem[3] = 32'h0000_0102;  // var1, hi=0, lo=2
    mem[4] = 32'h0000_0044;  // var0, hi=4, lo=4 (self-loop)
    mem[5] = 32'h0000_0F12;  // var15, hi=1, lo=2

    rst   = 1'b1;
    start = 2'b00;
    root[0] = 4'd0;
    root[1] = 4'd0;
    asg0  = '0;
    asg1  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/done", 32'(done[0]), 32'd0);
    check("rst/busy", 32'(busy[0]), 32'd0);
    check("rst/result", 32'(result[0]), 32'd0);
    check("rst/error", 32'(error[0]), 32'd0);
    check("rst/steps", 32'(steps[0]), 32'd0);
    check("rst/mem_addr", 32'(mem_addr[0]), 32'd0);
    check("rst/mem_write", 32'(mem_write), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1) root is a terminal
    run_walk(0, 4'd1, 16'h0000, 3, 1'b1, 1'b0, 5'd0, 1'b0, "s1_term");
    // 2) one internal node, both branches
    run_walk(0, 4'd0, 16'h0001, 5, 1'b1, 1'b0, 5'd1, 1'b0, "s2_hi");
    run_walk(0, 4'd0, 16'h0000, 5, 1'b0, 1'b0, 5'd1, 1'b0, "s2_lo");
    // 3) path 3 -> 0 -> 1
    run_walk(0, 4'd3, 16'h0003, 7, 1'b1, 1'b0, 5'd2, 1'b0, "s3_path");
    // 3b) path 3 -> 2 (var1 low)
    run_walk(0, 4'd3, 16'h0001, 5, 1'b0, 1'b0, 5'd1, 1'b0, "s3_lo");
    // 4) self-loop caught by the step limit
    run_walk(0, 4'd4, 16'h0000, 35, 1'b0, 1'b1, 5'd16, 1'b0, "s4_loop");
    // 5) variable index out of range on the 8-variable walker
    run_walk(1, 4'd5, 16'h00FF, 3, 1'b0, 1'b1, 5'd0, 1'b0, "s5_oob");
    // 5b) start pulsed while busy is ignored
    run_walk(0, 4'd3, 16'h0003, 7, 1'b1, 1'b0, 5'd2, 1'b1, "s5_poke");
    // 5c) var15 is legal on the 16-variable walker
    run_walk(0, 4'd5, 16'h8000, 5, 1'b1, 1'b0, 5'd1, 1'b0, "s5_var15");

    // Leave an error flag held, then reset in the middle of scenario 3.
    run_walk(0, 4'd4, 16'h0000, 35, 1'b0, 1'b1, 5'd16, 1'b0, "s6_pre");
    root[0]  = 4'd3;
    asg0     = 16'h0003;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    cnt = 1;
    repeat (5) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("s6/mid_busy", 32'(busy[0]), 32'd1);
    check("s6/mid_steps", 32'(steps[0]), 32'd2);
    check("s6/mid_addr", 32'(mem_addr[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("s6/rst_done", 32'(done[0]), 32'd0);
    check("s6/rst_busy", 32'(busy[0]), 32'd0);
    check("s6/rst_result", 32'(result[0]), 32'd0);
    check("s6/rst_error", 32'(error[0]), 32'd0);
    check("s6/rst_steps", 32'(steps[0]), 32'd0);
    check("s6/rst_addr", 32'(mem_addr[0]), 32'd0);
    $display("reset mid-walk at cycle %0d: dut0 busy=%0b steps=%0d", cnt, busy[0], steps[0]);
    run_walk(0, 4'd3, 16'h0003, 7, 1'b1, 1'b0, 5'd2, 1'b0, "s6_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
